// File: rtl/load_align_unit_if.sv
// Handshake bundle between the MEM-stage load unit, the pipeline and the data bus.
// The slave view belongs to the load unit; the master view belongs to the pipeline and memory side.
interface load_align_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_unsigned;

  logic              bus_rd_valid;
  logic [ADDR_W-1:0] bus_rd_addr;
  logic              bus_rd_ready;
  logic              bus_rdata_valid;
  logic [DATA_W-1:0] bus_rdata;

  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;
  logic              resp_ready;

  modport slave (
    input  req_valid, req_addr, req_size, req_unsigned,
    input  bus_rd_ready, bus_rdata_valid, bus_rdata,
    input  resp_ready,
    output req_ready, bus_rd_valid, bus_rd_addr,
    output resp_valid, resp_data, resp_err
  );

  modport master (
    output req_valid, req_addr, req_size, req_unsigned,
    output bus_rd_ready, bus_rdata_valid, bus_rdata,
    output resp_ready,
    input  req_ready, bus_rd_valid, bus_rd_addr,
    input  resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/load_align_unit.sv
// MEM-stage load unit: issues one or two beat-aligned bus reads, merges the beats,
// extracts the addressed byte/half/word/dword and sign- or zero-extends it.
module load_align_unit #(
  parameter int DATA_W           = 32,
  parameter int ADDR_W           = 32,
  parameter int SPLIT_MISALIGNED = 1
) (
  input logic              clk,
  input logic              reset_n,
  load_align_unit_if.slave lsu
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE0 = 3'd1;
  localparam logic [2:0] S_WAIT0  = 3'd2;
  localparam logic [2:0] S_ISSUE1 = 3'd3;
  localparam logic [2:0] S_WAIT1  = 3'd4;
  localparam logic [2:0] S_RESP   = 3'd5;

  logic [2:0]        r_state;
  logic [OFF_W-1:0]  r_off;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic              r_cross;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [DATA_W-1:0] r_beat0;
  logic [DATA_W-1:0] r_resp_data;
  logic              r_resp_err;

  logic [OFF_W-1:0]  w_req_off;
  logic [ADDR_W-1:0] w_req_base;
  logic [OFF_W+1:0]  w_req_span;
  logic [2:0]        w_align_mask;
  logic              w_req_illegal;
  logic              w_req_misal;
  logic              w_req_err;
  logic              w_req_cross;

  assign w_req_off  = lsu.req_addr[OFF_W-1:0];
  assign w_req_base = {lsu.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  // One past the last byte touched, relative to the beat base.
  assign w_req_span  = (OFF_W+2)'(w_req_off) + ((OFF_W+2)'(1) << lsu.req_size);
  assign w_req_cross = (w_req_span > (OFF_W+2)'(BYTES));

  always_comb begin
    w_align_mask = 3'b111;
    case (lsu.req_size)
      2'd0:    w_align_mask = 3'b000;
      2'd1:    w_align_mask = 3'b001;
      2'd2:    w_align_mask = 3'b011;
      default: w_align_mask = 3'b111;
    endcase
  end

  assign w_req_illegal = (lsu.req_size == 2'd3) && (DATA_W == 32);
  assign w_req_misal   = (SPLIT_MISALIGNED == 0) &&
                         ((lsu.req_addr[2:0] & w_align_mask) != 3'b000);
  assign w_req_err     = w_req_illegal || w_req_misal;

  // The final beat is merged straight off the bus so the result registers on the capture edge.
  logic [DATA_W-1:0] w_lo;
  logic [DATA_W-1:0] w_hi;
  logic [DATA_W-1:0] w_shifted;
  logic [DATA_W-1:0] w_mask;
  logic [DATA_W-1:0] w_result;
  logic              w_sign;
  logic [7:0]        w_pair [2*BYTES];

  assign w_lo = (r_state == S_WAIT1) ? r_beat0 : lsu.bus_rdata;
  assign w_hi = (r_state == S_WAIT1) ? lsu.bus_rdata : '0;

  generate
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
      logic [OFF_W:0] w_idx;
      assign w_pair[gi]         = w_lo[8*gi +: 8];
      assign w_pair[BYTES + gi] = w_hi[8*gi +: 8];
      assign w_idx              = (OFF_W+1)'(r_off) + (OFF_W+1)'(gi);
      assign w_shifted[8*gi +: 8] = w_pair[w_idx];
    end
  endgenerate

  always_comb begin
    w_mask = '1;
    w_sign = 1'b0;
    case (r_size)
      2'd0: begin
        w_mask = DATA_W'(64'h0000_0000_0000_00FF);
        w_sign = w_shifted[7];
      end
      2'd1: begin
        w_mask = DATA_W'(64'h0000_0000_0000_FFFF);
        w_sign = w_shifted[15];
      end
      2'd2: begin
        w_mask = DATA_W'(64'h0000_0000_FFFF_FFFF);
        w_sign = w_shifted[31];
      end
      default: begin
        w_mask = '1;
        w_sign = 1'b0;
      end
    endcase
  end

  assign w_result = (w_shifted & w_mask) | ((w_sign && !r_unsigned) ? ~w_mask : '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_off       <= '0;
      r_size      <= '0;
      r_unsigned  <= 1'b0;
      r_cross     <= 1'b0;
      r_base      <= '0;
      r_rd_addr   <= '0;
      r_beat0     <= '0;
      r_resp_data <= '0;
      r_resp_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (lsu.req_valid) begin
            r_off      <= w_req_off;
            r_size     <= lsu.req_size;
            r_unsigned <= lsu.req_unsigned;
            r_base     <= w_req_base;
            r_cross    <= w_req_cross;
            if (w_req_err) begin
              r_state     <= S_RESP;
              r_resp_err  <= 1'b1;
              r_resp_data <= '0;
            end else begin
              r_state   <= S_ISSUE0;
              r_rd_addr <= w_req_base;
            end
          end
        end
        S_ISSUE0: begin
          if (lsu.bus_rd_ready) r_state <= S_WAIT0;
        end
        S_WAIT0: begin
          if (lsu.bus_rdata_valid) begin
            r_beat0 <= lsu.bus_rdata;
            if (r_cross) begin
              r_state   <= S_ISSUE1;
              r_rd_addr <= r_base + ADDR_W'(BYTES);
            end else begin
              r_state     <= S_RESP;
              r_resp_data <= w_result;
              r_resp_err  <= 1'b0;
            end
          end
        end
        S_ISSUE1: begin
          if (lsu.bus_rd_ready) r_state <= S_WAIT1;
        end
        S_WAIT1: begin
          if (lsu.bus_rdata_valid) begin
            r_state     <= S_RESP;
            r_resp_data <= w_result;
            r_resp_err  <= 1'b0;
          end
        end
        S_RESP: begin
          if (lsu.resp_ready) begin
            r_state     <= S_IDLE;
            r_resp_data <= '0;
            r_resp_err  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign lsu.req_ready    = (r_state == S_IDLE);
  assign lsu.bus_rd_valid = (r_state == S_ISSUE0) || (r_state == S_ISSUE1);
  assign lsu.bus_rd_addr  = r_rd_addr;
  assign lsu.resp_valid   = (r_state == S_RESP);
  assign lsu.resp_data    = r_resp_data;
  assign lsu.resp_err     = r_resp_err;

endmodule
